// File: rtl/sync_sdm_inp_buf.sv
// SDM router input buffer: one FIFO per sub-channel, XY route of the head flit,
// and a per-sub-channel IDLE/REQ/XFER handshake with the switch allocator.
module sync_sdm_inp_buf #(
  parameter int VCN   = 1,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int DIR   = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [VCN-1:0]                          i_vld,
  input  logic [VCN-1:0][DW-1:0]                  i_data,
  input  logic [VCN-1:0]                          i_eof,
  output logic [VCN-1:0]                          i_rdy,
  output logic [VCN-1:0]                          o_vld,
  output logic [VCN-1:0]                          o_eof,
  output logic [VCN-1:0][DW-1:0]                  o_data,
  input  logic [VCN-1:0]                          o_rdy,
  output logic [VCN-1:0][4:0]                     arb_r,
  input  logic [VCN-1:0]                          arb_ra,
  input  logic [3:0]                              addrx,
  input  logic [3:0]                              addry,
  output logic [VCN-1:0][$clog2(DEPTH+1)-1:0]     occ,
  output logic [VCN-1:0]                          err
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Port index doubles as the bit position in the one-hot request {L,E,N,W,S}.
  typedef enum logic [2:0] {P_S = 3'd0, P_W = 3'd1, P_N = 3'd2, P_E = 3'd3, P_L = 3'd4} port_t;
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  for (genvar g = 0; g < VCN; g++) begin : g_ch
    logic [DW:0]    r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [OW-1:0]  r_occ;
    state_t         r_state, w_state_nxt;
    logic [4:0]     r_route;
    logic           r_err;
    logic [DW:0]    w_head;
    logic [3:0]     w_dx, w_dy;
    port_t          w_port;
    logic           w_uturn, w_load, w_push, w_pop;

    assign i_rdy[g]  = (r_occ < FULL);
    assign w_push    = i_vld[g] & i_rdy[g];
    assign w_pop     = o_vld[g] & o_rdy[g];
    assign w_head    = r_mem[r_rd_ptr];
    assign w_dx      = w_head[DW-1 -: 4];
    assign w_dy      = w_head[DW-5 -: 4];

    assign o_data[g] = w_head[DW-1:0];
    assign o_eof[g]  = w_head[DW];
    assign o_vld[g]  = (r_state == XFER) && (r_occ != '0);
    assign arb_r[g]  = (r_state == IDLE) ? 5'b0 : r_route;
    assign occ[g]    = r_occ;
    assign err[g]    = r_err;

    // NOTE: storage has no reset; r_occ alone decides whether an entry is visible.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {i_eof[g], i_data[g]};
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
      end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
      w_port = P_L;
      if      (w_dx > addrx) w_port = P_S;
      else if (w_dx < addrx) w_port = P_N;
      else if (w_dy > addry) w_port = P_E;
      else if (w_dy < addry) w_port = P_W;
      w_uturn = (DIR < 4) && (w_port == port_t'(3'(DIR)));
      if (w_uturn) w_port = P_L;
    end

    always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
        IDLE: if (r_occ != '0) begin
          w_load      = 1'b1;
          w_state_nxt = REQ;
        end
        REQ:  if (arb_ra[g]) w_state_nxt = XFER;
        XFER: if (w_pop && w_head[DW]) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= IDLE;
        r_route <= '0;
        r_err   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        if (w_load) r_route <= 5'b1 << w_port;
        if (w_load && w_uturn) r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_sdm_inp_buf.sv
// Directed bench: instance A (VCN=2, DIR=L) covers routing, FIFO limits, SDM
// independence and reset; instance B (DIR=S) covers the U-turn error.
module tb_sync_sdm_inp_buf;

  logic clk, rst;
  logic [3:0] addrx, addry;

  logic [1:0]        a_i_vld, a_i_eof, a_i_rdy, a_o_vld, a_o_eof, a_o_rdy, a_arb_ra, a_err;
  logic [1:0][31:0]  a_i_data, a_o_data;
  logic [1:0][4:0]   a_arb_r;
  logic [1:0][2:0]   a_occ;

  logic [0:0]        b_i_vld, b_i_eof, b_i_rdy, b_o_vld, b_o_eof, b_o_rdy, b_arb_ra, b_err;
  logic [0:0][31:0]  b_i_data, b_o_data;
  logic [0:0][4:0]   b_arb_r;
  logic [0:0][2:0]   b_occ;

  int n_chk  = 0;
  int n_pass = 0;

  sync_sdm_inp_buf #(.VCN(2), .DW(32), .DEPTH(4), .DIR(4)) u_a (
    .clk(clk), .rst(rst),
    .i_vld(a_i_vld), .i_data(a_i_data), .i_eof(a_i_eof), .i_rdy(a_i_rdy),
    .o_vld(a_o_vld), .o_eof(a_o_eof), .o_data(a_o_data), .o_rdy(a_o_rdy),
    .arb_r(a_arb_r), .arb_ra(a_arb_ra), .addrx(addrx), .addry(addry),
    .occ(a_occ), .err(a_err)
  );

  sync_sdm_inp_buf #(.VCN(1), .DW(32), .DEPTH(4), .DIR(0)) u_b (
    .clk(clk), .rst(rst),
    .i_vld(b_i_vld), .i_data(b_i_data), .i_eof(b_i_eof), .i_rdy(b_i_rdy),
    .o_vld(b_o_vld), .o_eof(b_o_eof), .o_data(b_o_data), .o_rdy(b_o_rdy),
    .arb_r(b_arb_r), .arb_ra(b_arb_ra), .addrx(addrx), .addry(addry),
    .occ(b_occ), .err(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] flit(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] id);
    return {dx, dy, 16'h0, id};
  endfunction

  initial begin
    rst = 1'b1; addrx = 4'd2; addry = 4'd2;
    a_i_vld = '0; a_i_eof = '0; a_i_data = '0; a_o_rdy = '0; a_arb_ra = '0;
    b_i_vld = '0; b_i_eof = '0; b_i_data = '0; b_o_rdy = '0; b_arb_ra = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_a_irdy",  64'(a_i_rdy), 64'h3);
    check("rst_a_occ",   64'(a_occ),   64'h0);
    check("rst_a_arb",   64'(a_arb_r), 64'h0);
    check("rst_a_ovld",  64'(a_o_vld), 64'h0);
    check("rst_a_err",   64'(a_err),   64'h0);
    check("rst_b_err",   64'(b_err),   64'h0);
    check("rst_b_irdy",  64'(b_i_rdy), 64'h1);

    // 3-flit packet routed S, granted in first REQ cycle
    a_arb_ra[0] = 1'b1; a_o_rdy[0] = 1'b1;
    a_i_vld[0] = 1'b1; a_i_data[0] = flit(3, 2, 8'h01); a_i_eof[0] = 1'b0;
    step();
    check("p3_idle_arb", 64'(a_arb_r[0]), 64'h0);
    check("p3_idle_occ", 64'(a_occ[0]),   64'h1);
    a_i_data[0] = flit(3, 2, 8'h02);
    step();
    check("p3_req_arb",  64'(a_arb_r[0]), 64'h01);
    check("p3_req_ovld", 64'(a_o_vld[0]), 64'h0);
    a_i_data[0] = flit(3, 2, 8'h03); a_i_eof[0] = 1'b1;
    step();
    a_i_vld[0] = 1'b0; a_i_eof[0] = 1'b0;
    check("p3_lat_ovld", 64'(a_o_vld[0]),  64'h1);
    check("p3_f1_data",  64'(a_o_data[0]), 64'(flit(3, 2, 8'h01)));
    check("p3_f1_occ",   64'(a_occ[0]),    64'h3);
    step();
    check("p3_f2_data",  64'(a_o_data[0]), 64'(flit(3, 2, 8'h02)));
    check("p3_f2_occ",   64'(a_occ[0]),    64'h2);
    step();
    check("p3_f3_data",  64'(a_o_data[0]), 64'(flit(3, 2, 8'h03)));
    check("p3_f3_eof",   64'(a_o_eof[0]),  64'h1);
    check("p3_f3_arb",   64'(a_arb_r[0]),  64'h01);
    step();
    check("p3_end_arb",  64'(a_arb_r[0]), 64'h0);
    check("p3_end_ovld", 64'(a_o_vld[0]), 64'h0);
    check("p3_end_occ",  64'(a_occ[0]),   64'h0);

    // Single-flit packet to the local port
    a_i_vld[0] = 1'b1; a_i_data[0] = flit(2, 2, 8'h11); a_i_eof[0] = 1'b1;
    step();
    a_i_vld[0] = 1'b0; a_i_eof[0] = 1'b0;
    check("sf_idle_arb", 64'(a_arb_r[0]), 64'h0);
    step();
    check("sf_req_arb",  64'(a_arb_r[0]), 64'h10);
    step();
    check("sf_xfer_arb", 64'(a_arb_r[0]), 64'h10);
    check("sf_xfer_vld", 64'(a_o_vld[0]), 64'h1);
    check("sf_xfer_eof", 64'(a_o_eof[0]), 64'h1);
    step();
    check("sf_end_arb",  64'(a_arb_r[0]), 64'h0);
    check("sf_end_occ",  64'(a_occ[0]),   64'h0);
    check("sf_end_vld",  64'(a_o_vld[0]), 64'h0);

    // Fill to DEPTH with no grant and no downstream ready
    a_arb_ra[0] = 1'b0; a_o_rdy[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_i_vld[0] = 1'b1; a_i_data[0] = flit(2, 3, 8'(i)); a_i_eof[0] = (i == 3);
      check("full_irdy", 64'(a_i_rdy[0]), (i < 4) ? 64'h1 : 64'h0);
      step();
    end
    a_i_vld[0] = 1'b0; a_i_eof[0] = 1'b0;
    check("full_occ",  64'(a_occ[0]),   64'h4);
    check("full_ovld", 64'(a_o_vld[0]), 64'h0);
    check("full_arb",  64'(a_arb_r[0]), 64'h08);
    a_arb_ra[0] = 1'b1;
    step();
    a_arb_ra[0] = 1'b0;
    check("full_xfer_vld", 64'(a_o_vld[0]),  64'h1);
    check("full_head",     64'(a_o_data[0]), 64'(flit(2, 3, 8'h00)));
    a_i_vld[0] = 1'b1; a_i_data[0] = flit(2, 3, 8'h09); a_o_rdy[0] = 1'b1;
    check("full_pop_irdy", 64'(a_i_rdy[0]), 64'h0);
    step();
    a_i_vld[0] = 1'b0;
    check("full_pop_occ", 64'(a_occ[0]),    64'h3);
    check("full_d1",      64'(a_o_data[0]), 64'(flit(2, 3, 8'h01)));
    step();
    check("full_d2",      64'(a_o_data[0]), 64'(flit(2, 3, 8'h02)));
    step();
    check("full_d3",      64'(a_o_data[0]), 64'(flit(2, 3, 8'h03)));
    check("full_d3_eof",  64'(a_o_eof[0]),  64'h1);
    check("full_hold_arb", 64'(a_arb_r[0]), 64'h08);
    step();
    check("full_end_arb", 64'(a_arb_r[0]), 64'h0);
    check("full_end_occ", 64'(a_occ[0]),   64'h0);

    // Two sub-channels: 0 routed E and stalled, 1 routed W and granted
    a_arb_ra = 2'b10; a_o_rdy = 2'b11;
    for (int i = 0; i < 3; i++) begin
      a_i_vld = 2'b11;
      a_i_data[0] = flit(2, 3, 8'(8'h10 + i));
      a_i_data[1] = flit(2, 1, 8'(8'h20 + i));
      a_i_eof = (i == 2) ? 2'b11 : 2'b00;
      step();
    end
    a_i_vld = 2'b00; a_i_eof = 2'b00;
    check("sdm_arb0", 64'(a_arb_r[0]), 64'h08);
    check("sdm_arb1", 64'(a_arb_r[1]), 64'h02);
    for (int j = 0; j < 3; j++) begin
      check("sdm_vld1",  64'(a_o_vld[1]),  64'h1);
      check("sdm_data1", 64'(a_o_data[1]), 64'(flit(2, 1, 8'(8'h20 + j))));
      check("sdm_vld0",  64'(a_o_vld[0]),  64'h0);
      step();
    end
    check("sdm_end_arb1", 64'(a_arb_r[1]), 64'h0);
    check("sdm_end_occ1", 64'(a_occ[1]),   64'h0);
    check("sdm_occ0",     64'(a_occ[0]),   64'h3);
    check("sdm_arb0_req", 64'(a_arb_r[0]), 64'h08);
    a_arb_ra = 2'b11;
    for (int j = 0; j < 5; j++) step();
    check("sdm_drain_occ0", 64'(a_occ[0]),   64'h0);
    check("sdm_drain_arb0", 64'(a_arb_r[0]), 64'h0);

    // Reset in the middle of a 5-flit packet after 2 pops
    for (int i = 0; i < 5; i++) begin
      a_i_vld[0] = 1'b1; a_i_data[0] = flit(3, 2, 8'(8'h30 + i)); a_i_eof[0] = (i == 4);
      step();
    end
    a_i_vld[0] = 1'b0; a_i_eof[0] = 1'b0;
    check("mid_occ",  64'(a_occ[0]),    64'h3);
    check("mid_head", 64'(a_o_data[0]), 64'(flit(3, 2, 8'h32)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_occ",  64'(a_occ[0]),   64'h0);
    check("mid_rst_arb",  64'(a_arb_r[0]), 64'h0);
    check("mid_rst_ovld", 64'(a_o_vld[0]), 64'h0);
    check("mid_rst_irdy", 64'(a_i_rdy[0]), 64'h1);
    step();
    check("mid_quiet_vld", 64'(a_o_vld[0]), 64'h0);
    a_i_vld[0] = 1'b1; a_i_data[0] = flit(1, 2, 8'h40); a_i_eof[0] = 1'b1;
    step();
    a_i_vld[0] = 1'b0; a_i_eof[0] = 1'b0;
    step();
    check("fresh_arb",  64'(a_arb_r[0]), 64'h04);
    step();
    check("fresh_vld",  64'(a_o_vld[0]),  64'h1);
    check("fresh_data", 64'(a_o_data[0]), 64'(flit(1, 2, 8'h40)));
    step();
    check("fresh_end_arb", 64'(a_arb_r[0]), 64'h0);
    check("fresh_end_occ", 64'(a_occ[0]),   64'h0);

    // U-turn on the S-arrival buffer
    b_arb_ra = 1'b1; b_o_rdy = 1'b1;
    check("ut_err_pre", 64'(b_err), 64'h0);
    b_i_vld = 1'b1; b_i_data[0] = flit(3, 2, 8'h50); b_i_eof = 1'b1;
    step();
    b_i_vld = 1'b0; b_i_eof = 1'b0;
    step();
    check("ut_arb", 64'(b_arb_r[0]), 64'h10);
    check("ut_err", 64'(b_err),      64'h1);
    step();
    check("ut_vld", 64'(b_o_vld), 64'h1);
    step();
    check("ut_end_arb", 64'(b_arb_r[0]), 64'h0);
    check("ut_end_occ", 64'(b_occ[0]),   64'h0);
    step(); step();
    check("ut_sticky", 64'(b_err), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ut_rst_err", 64'(b_err), 64'h0);
    b_i_vld = 1'b1; b_i_data[0] = flit(1, 2, 8'h51); b_i_eof = 1'b1;
    step();
    b_i_vld = 1'b0; b_i_eof = 1'b0;
    step();
    check("ut_n_arb", 64'(b_arb_r[0]), 64'h04);
    check("ut_n_err", 64'(b_err),      64'h0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
